mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 1024×16 single-port data/instruction memory. Shares the memory between the instruction-fetch unit (port 0) and the load/store unit (port 1) using round-robin arbitration. Generates the memory's address, write-enable and read-enable sequencing, and owns the direction of the shared bidirectional 16-bit data bus. Sits between the core's front/back ends and the memory instance.

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_if.sv | 32 +++
 rtl/mem_arbiter_rr.sv | 36 +++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and requester port ids.
// No latency or flow control of its own; imported by the arbiter RTL.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_ADDR = 2'd1,
        ST_RD_DATA = 2'd2,
        ST_WR      = 2'd3
    } state_e;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LSU   = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side handshake bundle for both arbiter ports (req/gnt/done, read data, busy).
// master = requesters, slave = the arbiter; gnt is combinational, done is a registered pulse.
interface mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              p0_req;
    logic              p1_req;
    logic              p0_we;
    logic              p1_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic [DATA_W-1:0] p1_wdata;
    logic              p0_gnt;
    logic              p1_gnt;
    logic              p0_done;
    logic              p1_done;
    logic [DATA_W-1:0] rd_data;
    logic              busy;

    modport master (
        output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
        input  p0_gnt, p1_gnt, p0_done, p1_done, rd_data, busy
    );

    modport slave (
        input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
        output p0_gnt, p1_gnt, p0_done, p1_done, rd_data, busy
    );

endinterface

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered last-winner pointer.
// Zero latency; a tie goes to the port that did not win last.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_o = req_i;
        if (&req_i) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (upd_i && (|gnt_o)) begin
            last_d = gnt_o[1];
        end
    end

    // Reset to port 1 so port 0 wins the very first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch (port 0) and LSU (port 1); owns the bidirectional bus.
// Read: gnt -> done 3 cycles later; write: gnt -> done 2 cycles later; requests only granted in IDLE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_if.slave      bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_en,
    output logic              mem_read_en,
    inout  wire  [DATA_W-1:0] mem_data
);

    state_e            state_q, state_d;
    logic              port_q, port_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [1:0]        done_q, done_d;

    logic [1:0] req;
    logic [1:0] arb_gnt;
    logic       is_idle;
    logic       arb_upd;

    assign is_idle = (state_q == ST_IDLE);
    assign req     = {bus.p1_req, bus.p0_req};
    assign arb_upd = is_idle && (|req);

    rr_arbiter2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .req_i (req),
        .upd_i (arb_upd),
        .gnt_o (arb_gnt)
    );

    assign bus.p0_gnt = is_idle & arb_gnt[0];
    assign bus.p1_gnt = is_idle & arb_gnt[1];

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        done_d    = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (arb_gnt[0]) begin
                    port_d  = PORT_FETCH;
                    addr_d  = bus.p0_addr;
                    wdata_d = bus.p0_wdata;
                    state_d = bus.p0_we ? ST_WR : ST_RD_ADDR;
                end else if (arb_gnt[1]) begin
                    port_d  = PORT_LSU;
                    addr_d  = bus.p1_addr;
                    wdata_d = bus.p1_wdata;
                    state_d = bus.p1_we ? ST_WR : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                rd_data_d      = mem_data;
                done_d[port_q] = 1'b1;
                state_d        = ST_IDLE;
            end
            ST_WR: begin
                done_d[port_q] = 1'b1;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            port_q    <= PORT_FETCH;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            done_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            done_q    <= done_d;
        end
    end

    // Enables decode straight from the state register, so read and write drive are mutually exclusive.
    assign mem_addr     = addr_q;
    assign mem_write_en = (state_q == ST_WR);
    assign mem_read_en  = (state_q == ST_RD_DATA);
    assign mem_data     = mem_write_en ? wdata_q : {DATA_W{1'bz}};

    assign bus.rd_data = rd_data_q;
    assign bus.p0_done = done_q[0];
    assign bus.p1_done = done_q[1];
    assign bus.busy    = !is_idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural 1024x16 single-port memory on the shared bus.
module tb_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    logic [AW-1:0] mem_addr;
    logic          mem_write_en;
    logic          mem_read_en;
    wire  [DW-1:0] mem_data;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .mem_addr     (mem_addr),
        .mem_write_en (mem_write_en),
        .mem_read_en  (mem_read_en),
        .mem_data     (mem_data)
    );

    // Memory model: clears itself on the first edge, captures read data on every non-write edge.
    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] mem_rq;
    logic          mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            mem_rq   <= '0;
            mem_init <= 1'b1;
        end else if (mem_write_en) begin
            mem[mem_addr] <= mem_data;
        end else begin
            mem_rq <= mem[mem_addr];
        end
    end

    assign mem_data = mem_read_en ? mem_rq : {DW{1'bz}};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          port;
        bit          rd;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          glog[$];
    logic [15:0] exp_mem [0:1023];
    exp_t        got_e;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Completion monitor and bus checker.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_read_en || mem_write_en)
                check_eq("bus_excl", 32'(mem_read_en & mem_write_en), 32'd0);
            if (mem_read_en) begin
                check_eq("bus_x", 32'($isunknown(mem_data)), 32'd0);
                check_eq("bus_rd", 32'(mem_data), 32'(mem_rq));
            end
            if (bus.p0_done || bus.p1_done) begin
                check_eq("done_excl", 32'(bus.p0_done & bus.p1_done), 32'd0);
                if (sb.size() == 0) begin
                    check_eq("unexp_done", 32'({bus.p1_done, bus.p0_done}), 32'd0);
                end else begin
                    got_e = sb.pop_front();
                    check_eq("done_port", 32'(bus.p1_done), 32'(got_e.port));
                    check_eq("done_cyc", 32'(cyc), 32'(got_e.cyc));
                    if (got_e.rd) check_eq("rd_data", 32'(bus.rd_data), 32'(got_e.data));
                end
            end
        end
    end

    task automatic drive_port(input int p, input logic req, input logic we,
                              input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (p == 0) begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = wd;
        end else begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = wd;
        end
    endtask

    // Raise a request, wait for its grant, log expectations, then release the request.
    task automatic access(input int p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, output int lat);
        bit got = 0;
        int start = cyc;
        lat = -1;
        drive_port(p, 1'b1, we, a, wd);
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if ((p == 0 && bus.p0_gnt) || (p == 1 && bus.p1_gnt)) begin
                got = 1;
                lat = cyc - start;
                glog.push_back(p);
                if (we) exp_mem[a] = wd;
                sb.push_back('{port: p, rd: !we, data: exp_mem[a], cyc: cyc + (we ? 2 : 3)});
            end
        end
        check_eq("gnt_seen", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        drive_port(p, 1'b0, 1'($urandom), AW'($urandom), DW'($urandom));
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (sb.size() != 0 || bus.busy); i++) @(negedge clk);
        check_eq("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_wen"}, 32'(mem_write_en), 32'd0);
        check_eq({tag, "_ren"}, 32'(mem_read_en), 32'd0);
        check_eq({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check_eq({tag, "_rdata"}, 32'(bus.rd_data), 32'd0);
        check_eq({tag, "_done"}, 32'({bus.p1_done, bus.p0_done}), 32'd0);
    endtask

    int lat;

    initial begin
        for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
        drive_port(0, 1'b0, 1'b0, '0, '0);
        drive_port(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single-port write then read on port 0.
        access(0, 1'b1, 10'h005, 16'hBEEF, lat);
        check_eq("wr_gnt_lat", 32'(lat), 32'd0);
        drain();
        access(0, 1'b0, 10'h005, 16'h0000, lat);
        check_eq("rd_gnt_lat", 32'(lat), 32'd0);
        drain();

        // Preload through port 1, reset, then a same-cycle read collision.
        access(1, 1'b1, 10'h001, 16'h1111, lat);
        access(1, 1'b1, 10'h002, 16'h2222, lat);
        drain();
        pulse_reset();
        glog.delete();
        fork
            access(0, 1'b0, 10'h001, 16'h0000, lat);
            access(1, 1'b0, 10'h002, 16'h0000, lat);
        join
        drain();
        check_eq("tie_first", 32'(glog[0]), 32'd0);
        check_eq("tie_second", 32'(glog[1]), 32'd1);

        // Both ports requesting continuously: strict alternation from reset.
        pulse_reset();
        glog.delete();
        fork
            begin
                int l0;
                for (int i = 0; i < 3; i++) access(0, 1'b1, AW'(10'h020 + i), DW'(16'hA000 + i * 16'h111), l0);
            end
            begin
                int l1;
                for (int i = 0; i < 3; i++) access(1, 1'b0, AW'(10'h020 + i), 16'h0000, l1);
            end
        join
        drain();
        check_eq("alt_count", 32'(glog.size()), 32'd6);
        for (int i = 0; i < glog.size(); i++) check_eq("alt_order", 32'(glog[i]), 32'(i % 2));

        // Address boundary: no aliasing between 0x3FF and 0x000.
        access(0, 1'b1, 10'h3FF, 16'hFFFF, lat);
        access(1, 1'b0, 10'h000, 16'h0000, lat);
        access(0, 1'b0, 10'h3FF, 16'h0000, lat);
        drain();

        // Reset during RD_DATA.
        drive_port(0, 1'b1, 1'b0, 10'h005, 16'h0000);
        @(negedge clk);
        check_eq("ab_rd_gnt", 32'(bus.p0_gnt), 32'd1);
        @(posedge clk);
        #1;
        drive_port(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        check_eq("ab_rd_state", 32'(mem_read_en), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("ab_rd");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("ab_rd_nodone", 32'({bus.p1_done, bus.p0_done}), 32'd0);

        // Reset during WR: memory word must keep its old value.
        drive_port(1, 1'b1, 1'b1, 10'h005, 16'h1234);
        @(negedge clk);
        check_eq("ab_wr_gnt", 32'(bus.p1_gnt), 32'd1);
        @(posedge clk);
        #1;
        drive_port(1, 1'b0, 1'b0, '0, '0);
        check_eq("ab_wr_state", 32'(mem_write_en), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("ab_wr");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        access(0, 1'b0, 10'h005, 16'h0000, lat);
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
